// File: rtl/te_sync_scheduler_if.sv
// Sync-scheduler port bundle: trace control inputs, trigger pulses and the
// valid/ready sync request toward the packet builder.
interface te_sync_scheduler_if #(
    parameter int PERIOD_W = 20,
    parameter int RCNT_W   = 3
);
    logic                trace_enable_i;
    logic [1:0]          sync_mode_i;
    logic [PERIOD_W-1:0] sync_period_i;
    logic                pkt_sent_i;
    logic [RCNT_W-1:0]   iretire_cnt_i;
    logic                debug_exit_i;
    logic                pwr_exit_i;
    logic                fifo_restart_i;
    logic                ext_trig_i;
    logic                trace_event_i;
    logic                sync_valid_o;
    logic                sync_ready_i;
    logic [3:0]          sync_cause_o;
    logic [PERIOD_W-1:0] period_cnt_o;

    modport master (
        input  trace_enable_i, sync_mode_i, sync_period_i, pkt_sent_i, iretire_cnt_i,
        input  debug_exit_i, pwr_exit_i, fifo_restart_i, ext_trig_i, trace_event_i,
        input  sync_ready_i,
        output sync_valid_o, sync_cause_o, period_cnt_o
    );

    modport slave (
        output trace_enable_i, sync_mode_i, sync_period_i, pkt_sent_i, iretire_cnt_i,
        output debug_exit_i, pwr_exit_i, fifo_restart_i, ext_trig_i, trace_event_i,
        output sync_ready_i,
        input  sync_valid_o, sync_cause_o, period_cnt_o
    );
endinterface

// File: rtl/te_sync_scheduler.sv
// PROGTRACESYNC request sequencer: arbitrates sync triggers and the periodic counter.
// Periodic sync is built only when TE_SYNC_PERIODIC_EN is defined.
module te_sync_scheduler #(
    parameter int PERIOD_W = 20,
    parameter int RETIRE_W = 6,
    parameter int RCNT_W   = $clog2(RETIRE_W + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    te_sync_scheduler_if.master  sif
);
    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_REQ} state_e;

    localparam logic [3:0] C_EXT_TRIG  = 4'h0;
    localparam logic [3:0] C_RESET     = 4'h1;
    localparam logic [3:0] C_PERIODIC  = 4'h2;
    localparam logic [3:0] C_DEBUG     = 4'h3;
    localparam logic [3:0] C_TRACE_EN  = 4'h5;
    localparam logic [3:0] C_EVENT     = 4'h6;
    localparam logic [3:0] C_FIFO      = 4'h7;
    localparam logic [3:0] C_PWR       = 4'h9;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [3:0]          cause_q, cause_d;
    logic                first_q, first_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_next;
    logic                per_fire, mode_chg;
    logic                trig_any;

`ifdef TE_SYNC_PERIODIC_EN
    logic [1:0]          mode_q;
    logic [PERIOD_W-1:0] inc;
    logic [PERIOD_W:0]   sum;

    assign mode_chg = (sif.sync_mode_i != mode_q);

    always_comb begin
        inc = '0;
        unique case (sif.sync_mode_i)
            2'd1: inc = PERIOD_W'(sif.pkt_sent_i);
            2'd2: inc = PERIOD_W'(1);
            2'd3: inc = (sif.iretire_cnt_i > RCNT_W'(RETIRE_W)) ? PERIOD_W'(RETIRE_W)
                                                                 : PERIOD_W'(sif.iretire_cnt_i);
            default: inc = '0;
        endcase
        sum = {1'b0, cnt_q} + {1'b0, inc};
        // Saturate rather than wrap so a large threshold is still reached.
        cnt_next = mode_chg ? '0 : (sum[PERIOD_W] ? '1 : sum[PERIOD_W-1:0]);
        per_fire = (sif.sync_period_i != '0) && (cnt_next >= sif.sync_period_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mode_q <= 2'd0;
        else          mode_q <= sif.sync_mode_i;
    end
`else
    logic unused_periodic;

    assign mode_chg = 1'b0;
    assign cnt_next = '0;
    assign per_fire = 1'b0;
    assign unused_periodic = ^{sif.sync_mode_i, sif.sync_period_i, sif.pkt_sent_i,
                               sif.iretire_cnt_i, RCNT_W'(RETIRE_W)};
`endif

    assign trig_any = sif.debug_exit_i | sif.pwr_exit_i | sif.fifo_restart_i |
                      sif.ext_trig_i | sif.trace_event_i;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        cause_d = cause_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        if (!sif.trace_enable_i) begin
            // Disable is the only case where a pending request is withdrawn.
            state_d = ST_OFF;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_REQ;
                    valid_d = 1'b1;
                    cause_d = first_q ? C_RESET : C_TRACE_EN;
                    first_d = 1'b0;
                    cnt_d   = '0;
                end
                ST_RUN: begin
                    cnt_d = cnt_next;
                    if (trig_any || per_fire) begin
                        state_d = ST_REQ;
                        valid_d = 1'b1;
                        if      (sif.debug_exit_i)   cause_d = C_DEBUG;
                        else if (sif.pwr_exit_i)     cause_d = C_PWR;
                        else if (sif.fifo_restart_i) cause_d = C_FIFO;
                        else if (sif.ext_trig_i)     cause_d = C_EXT_TRIG;
                        else if (sif.trace_event_i)  cause_d = C_EVENT;
                        else                         cause_d = C_PERIODIC;
                    end
                end
                ST_REQ: begin
                    // Triggers arriving here are covered by the pending sync.
                    if (sif.sync_ready_i) begin
                        state_d = ST_RUN;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end else if (mode_chg) begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
            valid_q <= 1'b0;
            cause_q <= 4'h0;
            first_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cause_q <= cause_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sif.sync_valid_o = valid_q;
    assign sif.sync_cause_o = cause_q;
    assign sif.period_cnt_o = cnt_q;
endmodule

// File: tb/tb_te_sync_scheduler.sv
// Bench for te_sync_scheduler: directed scenarios then random traffic, scored
// against a cycle-level reference model and a queue of expected sync causes.
module tb_te_sync_scheduler;
    localparam int PW = 8;
    localparam int CMAX = (1 << PW) - 1;
`ifdef TE_SYNC_PERIODIC_EN
    localparam bit PERIODIC = 1'b1;
`else
    localparam bit PERIODIC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    te_sync_scheduler_if #(.PERIOD_W(PW), .RCNT_W(3)) bus();
    te_sync_scheduler #(.PERIOD_W(PW), .RETIRE_W(6), .RCNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .sif(bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    bit m_on = 0, m_pend = 0, m_first = 1, mon_on = 0;
    int m_cnt = 0;
    int m_mode = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the sync rules say should happen at this clock edge.
    task automatic model_step();
        int inc, nxt, cause;
        bit mchg;
        mchg = (int'(bus.sync_mode_i) != m_mode);
        m_mode = int'(bus.sync_mode_i);
        if (!bus.trace_enable_i) begin
            if (m_pend) void'(exp_q.pop_back());
            m_pend = 0; m_on = 0; m_cnt = 0;
        end else if (!m_on) begin
            m_on = 1; m_pend = 1; m_cnt = 0;
            exp_q.push_back(m_first ? 1 : 5);
            m_first = 0;
        end else if (m_pend) begin
            if (bus.sync_ready_i) begin m_pend = 0; m_cnt = 0; end
            else if (mchg) m_cnt = 0;
        end else begin
            case (m_mode)
                1: inc = int'(bus.pkt_sent_i);
                2: inc = 1;
                3: inc = int'(bus.iretire_cnt_i);
                default: inc = 0;
            endcase
            nxt = mchg ? 0 : m_cnt + inc;
            if (nxt > CMAX) nxt = CMAX;
            if (!PERIODIC) nxt = 0;
            m_cnt = nxt;
            cause = -1;
            if      (bus.debug_exit_i)   cause = 3;
            else if (bus.pwr_exit_i)     cause = 9;
            else if (bus.fifo_restart_i) cause = 7;
            else if (bus.ext_trig_i)     cause = 0;
            else if (bus.trace_event_i)  cause = 6;
            else if (PERIODIC && bus.sync_period_i != 0 && nxt >= int'(bus.sync_period_i)) cause = 2;
            if (cause >= 0) begin exp_q.push_back(cause); m_pend = 1; end
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #2;
        end
    endtask

    task automatic clr_trig();
        bus.debug_exit_i = 0; bus.pwr_exit_i = 0; bus.fifo_restart_i = 0;
        bus.ext_trig_i = 0; bus.trace_event_i = 0;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("valid", int'(bus.sync_valid_o), int'(m_pend));
            chk("period_cnt", int'(bus.period_cnt_o), m_cnt);
            if (bus.sync_valid_o && exp_q.size() > 0)
                chk("cause_hold", int'(bus.sync_cause_o), exp_q[0]);
            if (bus.sync_valid_o && bus.sync_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL handshake: got cause %0d expected no request at %0t",
                             bus.sync_cause_o, $time);
                end else begin
                    chk("cause", int'(bus.sync_cause_o), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.trace_enable_i = 0; bus.sync_mode_i = 0; bus.sync_period_i = 0;
        bus.pkt_sent_i = 0; bus.iretire_cnt_i = 0; bus.sync_ready_i = 0;
        clr_trig();
        repeat (2) @(negedge clk);
        chk("reset_valid", int'(bus.sync_valid_o), 0);
        chk("reset_cause", int'(bus.sync_cause_o), 0);
        chk("reset_cnt", int'(bus.period_cnt_o), 0);
        @(posedge clk); #2;
        reset_n = 1; mon_on = 1;

        // First enable gives EXIT_FROM_RESET, re-enable gives TRACE_ENABLE.
        tick(4);
        bus.trace_enable_i = 1; tick();
        bus.sync_ready_i = 1; tick(); bus.sync_ready_i = 0; tick(2);
        bus.trace_enable_i = 0; tick(2);
        bus.trace_enable_i = 1; tick();
        bus.sync_ready_i = 1; tick(); bus.sync_ready_i = 0; tick();

        // Simultaneous debug exit and external trigger.
        bus.debug_exit_i = 1; bus.ext_trig_i = 1; tick(); clr_trig(); tick(2);
        bus.sync_ready_i = 1; tick(); bus.sync_ready_i = 0; tick(2);

        // Retire-count periodic sync, 6 per cycle against threshold 20.
        bus.sync_mode_i = 3; bus.sync_period_i = 20; bus.iretire_cnt_i = 6; tick(6);
        bus.sync_ready_i = 1; tick(); bus.sync_ready_i = 0;
        bus.iretire_cnt_i = 0; bus.sync_mode_i = 0; bus.sync_period_i = 0; tick(2);

        // Long stall with absorbed fifo restarts.
        bus.ext_trig_i = 1; tick(); clr_trig();
        for (int i = 0; i < 10; i++) begin
            bus.fifo_restart_i = (i % 2 == 0); tick();
        end
        clr_trig();
        bus.sync_ready_i = 1; bus.fifo_restart_i = 1; tick();
        bus.sync_ready_i = 0; clr_trig(); tick(3);

        // Disable while request is pending and unaccepted.
        bus.trace_event_i = 1; tick(); clr_trig(); tick();
        bus.trace_enable_i = 0; tick(3);
        bus.trace_enable_i = 1; tick();
        bus.sync_ready_i = 1; tick(); bus.sync_ready_i = 0; tick();

        // Cycle counter saturation, then fire at the saturated value.
        bus.sync_mode_i = 2; tick(CMAX + 20);
        bus.sync_period_i = PW'(CMAX); tick(2);
        bus.sync_ready_i = 1; tick(); bus.sync_ready_i = 0;
        bus.sync_period_i = 0; bus.sync_mode_i = 1; tick(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (bus.trace_enable_i) bus.trace_enable_i = ($urandom_range(0, 79) != 0);
            else                    bus.trace_enable_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                bus.sync_mode_i = 2'($urandom_range(0, 3));
                bus.sync_period_i = PW'($urandom_range(0, 40));
            end
            bus.pkt_sent_i = 1'($urandom_range(0, 1));
            bus.iretire_cnt_i = 3'($urandom_range(0, 6));
            bus.debug_exit_i   = ($urandom_range(0, 29) == 0);
            bus.pwr_exit_i     = ($urandom_range(0, 29) == 0);
            bus.fifo_restart_i = ($urandom_range(0, 29) == 0);
            bus.ext_trig_i     = ($urandom_range(0, 29) == 0);
            bus.trace_event_i  = ($urandom_range(0, 29) == 0);
            bus.sync_ready_i   = bus.trace_enable_i ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end

        clr_trig();
        bus.trace_enable_i = 1; bus.sync_ready_i = 1; tick(3);
        mon_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
